// File: rtl/bnn_host_pkg.sv
// ============================================================================
// Module  : bnn_host_pkg
// Brief   : Shared state encoding and sizing helper for the BNN stream host.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package bnn_host_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESULT = 2'd2
    } host_state_t;

    // A single class still needs a one-bit prediction field.
    function automatic int pred_width(input int class_cnt);
        return (class_cnt > 1) ? $clog2(class_cnt) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_frame_assembler.sv
// ============================================================================
// Module  : bnn_frame_assembler
// Brief   : Writes stream beats into the parallel feature vector and flags
//           frames whose s_last does not land on the final slot.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bnn_frame_assembler #(
    parameter int FEAT_CNT  = 12,
    parameter int FEAT_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_load_en,
    input  logic                          i_valid,
    input  logic [FEAT_BITS-1:0]          i_data,
    input  logic                          i_last,
    output logic [FEAT_CNT*FEAT_BITS-1:0] o_features,
    output logic                          o_frame_err,
    output logic                          o_frame_done
);

    localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;

    logic [IDX_W-1:0]              r_idx;
    logic [FEAT_CNT*FEAT_BITS-1:0] r_features;
    logic                          r_frame_err;

    logic w_accept;
    logic w_at_end;
    logic w_err;

    assign w_accept     = i_load_en & i_valid;
    assign w_at_end     = (r_idx == IDX_W'(FEAT_CNT - 1));
    // s_last must coincide exactly with the final slot.
    assign w_err        = w_accept & (w_at_end ^ i_last);
    assign o_frame_done = w_accept & w_at_end & i_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx       <= '0;
            r_features  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (w_accept) begin
                r_features[r_idx*FEAT_BITS +: FEAT_BITS] <= i_data;
                r_idx <= (w_at_end | i_last) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign o_features  = r_features;
    assign o_frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: rtl/bnn_stream_host.sv
// ============================================================================
// Module  : bnn_stream_host
// Brief   : Loads a feature frame, runs the BNN for a fixed window, and hands
//           the sampled prediction downstream over valid/ready.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bnn_stream_host
    import bnn_host_pkg::*;
#(
    parameter int FEAT_CNT     = 12,
    parameter int FEAT_BITS    = 4,
    parameter int CLASS_CNT    = 6,
    parameter int INFER_CYCLES = 48
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [FEAT_BITS-1:0]               s_data,
    input  logic                               s_last,
    output logic [FEAT_CNT*FEAT_BITS-1:0]      features,
    output logic                               bnn_rst,
    input  logic [pred_width(CLASS_CNT)-1:0]   prediction,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [pred_width(CLASS_CNT)-1:0]   m_pred,
    output logic                               frame_err
);

    localparam int PRED_W = pred_width(CLASS_CNT);
    localparam int CNT_W  = (INFER_CYCLES > 1) ? $clog2(INFER_CYCLES) : 1;

    host_state_t       r_state;
    host_state_t       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_bnn_rst;
    logic              w_bnn_rst_next;
    logic              r_m_valid;
    logic              w_m_valid_next;
    logic [PRED_W-1:0] r_m_pred;
    logic [PRED_W-1:0] w_m_pred_next;
    logic              w_s_ready;
    logic              w_frame_done;

    // The reset term keeps s_ready low while rst is held, even though the
    // state register already reads LOAD.
    assign w_s_ready = rst & (r_state == ST_LOAD);

    bnn_frame_assembler #(
        .FEAT_CNT  (FEAT_CNT),
        .FEAT_BITS (FEAT_BITS)
    ) u_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_load_en    (w_s_ready),
        .i_valid      (s_valid),
        .i_data       (s_data),
        .i_last       (s_last),
        .o_features   (features),
        .o_frame_err  (frame_err),
        .o_frame_done (w_frame_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_LOAD;
            r_cnt     <= '0;
            r_bnn_rst <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_pred  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bnn_rst <= w_bnn_rst_next;
            r_m_valid <= w_m_valid_next;
            r_m_pred  <= w_m_pred_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bnn_rst_next = r_bnn_rst;
        w_m_valid_next = r_m_valid;
        w_m_pred_next  = r_m_pred;
        case (r_state)
            ST_LOAD: begin
                w_bnn_rst_next = 1'b1;
                if (w_frame_done) begin
                    w_state_next   = ST_RUN;
                    w_cnt_next     = CNT_W'(INFER_CYCLES - 1);
                    w_bnn_rst_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_state_next   = ST_RESULT;
                    w_m_pred_next  = prediction;
                    w_m_valid_next = 1'b1;
                    w_bnn_rst_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_RESULT: begin
                if (m_ready) begin
                    w_m_valid_next = 1'b0;
                    w_state_next   = ST_LOAD;
                end
            end
            default: begin
                w_state_next   = ST_LOAD;
                w_bnn_rst_next = 1'b1;
                w_m_valid_next = 1'b0;
            end
        endcase
    end

    assign s_ready = w_s_ready;
    assign bnn_rst = r_bnn_rst;
    assign m_valid = r_m_valid;
    assign m_pred  = r_m_pred;

endmodule

`default_nettype wire

// File: tb/tb_bnn_stream_host.sv
// ============================================================================
// Module  : tb_bnn_stream_host
// Brief   : Directed bench with a frame-level reference model and stub BNN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_bnn_stream_host;

    localparam int FEAT_CNT     = 12;
    localparam int FEAT_BITS    = 4;
    localparam int CLASS_CNT    = 6;
    localparam int INFER_CYCLES = 48;
    localparam int FW           = FEAT_CNT * FEAT_BITS;
    localparam logic [47:0] GOLD = 48'hCBA987654321;
    localparam logic [47:0] FIVE = 48'h555555555555;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [3:0]     s_data = 4'h0;
    logic           s_last = 1'b0;
    logic [FW-1:0]  features;
    logic           bnn_rst;
    logic [2:0]     prediction;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [2:0]     m_pred;
    logic           frame_err;

    bnn_stream_host #(
        .FEAT_CNT     (FEAT_CNT),
        .FEAT_BITS    (FEAT_BITS),
        .CLASS_CNT    (CLASS_CNT),
        .INFER_CYCLES (INFER_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .features   (features),
        .bnn_rst    (bnn_rst),
        .prediction (prediction),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_pred     (m_pred),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Stub BNN: recognises the two reference frames.
    function automatic logic [2:0] stub_pred(input logic [FW-1:0] f);
        if (f == GOLD) return 3'd3;
        if (f == FIVE) return 3'd5;
        return 3'd2;
    endfunction

    assign prediction = stub_pred(features);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: slots filled so far, cycles of inference remaining,
    // and a pending result.
    logic [3:0] mdl_slot [FEAT_CNT];
    int         mdl_nb    = 0;
    int         mdl_run   = 0;
    bit         mdl_res_v = 1'b0;
    logic [2:0] mdl_res   = 3'd0;
    bit         mdl_err   = 1'b0;
    int         edge_no   = 0;
    int         acc_edge  = 0;
    logic [2:0] got [$];

    function automatic logic [FW-1:0] mdl_feat();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < FEAT_CNT; i++) f[i*4 +: 4] = mdl_slot[i];
        return f;
    endfunction

    initial begin
        for (int i = 0; i < FEAT_CNT; i++) mdl_slot[i] = 4'h0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < FEAT_CNT; i++) mdl_slot[i] = 4'h0;
                mdl_nb = 0; mdl_run = 0; mdl_res_v = 1'b0; mdl_res = 3'd0; mdl_err = 1'b0;
            end else begin
                edge_no++;
                mdl_err = 1'b0;
                if (mdl_run > 0) begin
                    mdl_run--;
                    if (mdl_run == 0) begin
                        mdl_res_v = 1'b1;
                        mdl_res   = stub_pred(mdl_feat());
                    end
                end else if (mdl_res_v) begin
                    if (m_ready) begin
                        got.push_back(m_pred);
                        mdl_res_v = 1'b0;
                    end
                end else if (s_valid) begin
                    mdl_slot[mdl_nb] = s_data;
                    mdl_nb++;
                    if ((mdl_nb == FEAT_CNT) != s_last) begin
                        mdl_err = 1'b1;
                        mdl_nb  = 0;
                    end else if (s_last) begin
                        mdl_nb   = 0;
                        mdl_run  = INFER_CYCLES;
                        acc_edge = edge_no;
                    end
                end
            end
        end
    end

    bit chk_en    = 1'b0;
    int low_cnt   = 0;
    int err_cnt   = 0;
    int rise_cnt  = 0;
    int rise_edge = 0;
    bit prev_mv   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("s_ready",   s_ready,   rst && mdl_run == 0 && !mdl_res_v);
                check("bnn_rst",   bnn_rst,   mdl_run == 0);
                check("m_valid",   m_valid,   mdl_res_v);
                check("m_pred",    m_pred,    mdl_res);
                check("frame_err", frame_err, mdl_err);
                check("features",  features,  mdl_feat());
            end
            if (!bnn_rst) low_cnt++;
            if (frame_err) err_cnt++;
            if (m_valid && !prev_mv) begin
                rise_cnt++;
                rise_edge = edge_no;
            end
            prev_mv = m_valid;
        end
    end

    task automatic send_beat(input logic [3:0] d, input logic l);
        int guard;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        guard = 0;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            n_checks++;
            $display("FAIL beat_accept: s_ready got 0 expected 1 after 200 cycles");
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // last_at: 1-based beat carrying s_last, 0 for none.
    task automatic send_frame(input logic [FW-1:0] f, input int last_at, input int nbeats, input bit keep);
        for (int i = 0; i < nbeats; i++) send_beat(f[i*4 +: 4], (i + 1) == last_at);
        if (!keep) drop_valid();
    endtask

    task automatic wait_mvalid(output logic [2:0] p);
        int guard;
        guard = 0;
        while (!m_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!m_valid) begin
            n_checks++;
            $display("FAIL wait_mvalid: m_valid got 0 expected 1 after 200 cycles");
        end
        p = m_pred;
    endtask

    initial begin
        logic [2:0] p;
        int lo0, e0, r0, g0, guard;

        #1 rst = 1'b0;
        #3;
        check("rst_features",  features,  48'h0);
        check("rst_bnn_rst",   bnn_rst,   1'b1);
        check("rst_s_ready",   s_ready,   1'b0);
        check("rst_m_valid",   m_valid,   1'b0);
        check("rst_m_pred",    m_pred,    3'd0);
        check("rst_frame_err", frame_err, 1'b0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Golden frame, then hold the result under backpressure.
        m_ready = 1'b0;
        lo0 = low_cnt;
        send_frame(GOLD, 12, 12, 1'b0);
        wait_mvalid(p);
        check("gold_features", features, GOLD);
        check("gold_pred", p, 3'd3);
        check("gold_latency", rise_edge - acc_edge + 1, INFER_CYCLES + 1);
        check("gold_bnn_rst_low", low_cnt - lo0, INFER_CYCLES);
        s_valid = 1'b1; s_data = 4'hF; s_last = 1'b1;
        repeat (20) @(negedge clk);
        check("bp_m_valid", m_valid, 1'b1);
        check("bp_m_pred",  m_pred,  3'd3);
        check("bp_s_ready", s_ready, 1'b0);
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        check("bp_release_s_ready", s_ready, 1'b1);
        check("bp_release_m_valid", m_valid, 1'b0);

        // Early s_last on beat 5, then a clean all-5 frame.
        e0 = err_cnt;
        send_frame(GOLD, 5, 5, 1'b0);
        repeat (3) @(negedge clk);
        check("early_err_pulses", err_cnt - e0, 1);
        check("early_bnn_rst", bnn_rst, 1'b1);
        send_frame(FIVE, 12, 12, 1'b0);
        wait_mvalid(p);
        check("five_features", features, FIVE);
        check("five_pred", p, 3'd5);

        // Missing s_last on beat 12, then a clean frame from slot 0.
        e0 = err_cnt;
        send_frame(GOLD, 0, 12, 1'b0);
        repeat (3) @(negedge clk);
        check("miss_err_pulses", err_cnt - e0, 1);
        check("miss_bnn_rst", bnn_rst, 1'b1);
        send_frame(GOLD, 12, 12, 1'b0);
        wait_mvalid(p);
        check("after_miss_pred", p, 3'd3);

        // Asynchronous reset in the middle of inference.
        send_frame(FIVE, 12, 12, 1'b0);
        guard = 0;
        while (mdl_run != 11 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        #2 rst = 1'b0;
        #1;
        check("arst_bnn_rst",   bnn_rst,   1'b1);
        check("arst_s_ready",   s_ready,   1'b0);
        check("arst_m_valid",   m_valid,   1'b0);
        check("arst_features",  features,  48'h0);
        check("arst_frame_err", frame_err, 1'b0);
        r0 = rise_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("arst_no_result", rise_cnt - r0, 0);
        send_frame(FIVE, 12, 12, 1'b0);
        wait_mvalid(p);
        check("arst_recover_pred", p, 3'd5);

        // Back-to-back frames with s_valid and m_ready held high.
        @(negedge clk);
        g0 = got.size();
        send_frame(GOLD, 12, 12, 1'b1);
        send_frame(FIVE, 12, 12, 1'b0);
        wait_mvalid(p);
        repeat (3) @(negedge clk);
        check("b2b_count", got.size() - g0, 2);
        if (got.size() - g0 == 2) begin
            check("b2b_first",  got[g0],     3'd3);
            check("b2b_second", got[g0 + 1], 3'd5);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
